vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 16: VRAM word-address width; DEPTH = 2**ADDR_W bytes.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk_sys  in  1  sole clock; the VRAM also runs on it
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  HPS download window active
- ioctl_wr  in  1  one-cycle write strobe from hps_io
- ioctl_addr  in  27  byte address of the write
- ioctl_dout  in  8  write data
- ioctl_wait  out  1  backpressure to hps_io
- clr_req  in  1  one-cycle request to zero-fill the VRAM
- vid_req  in  1  pixel fetch request from video timing
- vid_addr  in  ADDR_W  pixel fetch address
- vid_data  out  8  fetched pixel
- vid_valid  out  1  vid_data valid strobe
- ram_addr  out  ADDR_W  VRAM address, registered
- ram_din  out  8  VRAM write data, registered
- ram_we  out  1  VRAM write enable, registered
- ram_dout  in  8  VRAM read data, valid one cycle after ram_addr
- busy  out  1  state not IDLE
- dl_done  out  1  one-cycle pulse at download completion
- err  out  2  sticky flags: [0] address out of range, [1] write lost

Function
REQ-003 The block SHALL share a single-port synchronous VRAM between three requesters: video fetch, download write and clear fill.
REQ-004 Fixed priority SHALL be video > download write > clear; exactly one RAM access SHALL be issued per cycle at most.
REQ-005 Video fetch SHALL never stall: vid_req in cycle N drives ram_addr=vid_addr, ram_we=0 in N+1; vid_valid=1 with vid_data=ram_dout captured in N+3; total latency 3 cycles, fully pipelined, back-to-back requests allowed.
REQ-006 A 2-entry write FIFO SHALL hold {addr[ADDR_W-1:0], data}; ioctl_wr pushes and a granted write slot pops.
REQ-007 ioctl_wait SHALL be registered and equal 1 when FIFO occupancy is >=1 at the end of the cycle, so one in-flight write is always absorbed.
REQ-008 ioctl_wr with a full FIFO SHALL drop the write and set err[1]; a simultaneous push and pop on a full FIFO SHALL be accepted.
REQ-009 ioctl_wr with ioctl_addr >= DEPTH SHALL drop the write, set err[0] and leave the FIFO unchanged.
REQ-010 The state machine SHALL have states IDLE, DOWNLOAD, FLUSH, CLEAR, DONE.
REQ-011 IDLE->DOWNLOAD on a rising edge of ioctl_download, which clears err; this transition SHALL take precedence over clr_req in the same cycle.
REQ-012 IDLE->CLEAR on clr_req with ioctl_download=0; clr_req in any other state SHALL be ignored.
REQ-013 DOWNLOAD->FLUSH on a falling edge of ioctl_download; ioctl_wr is still accepted during FLUSH.
REQ-014 FLUSH->DONE when the FIFO is empty and no write is in the RAM pipeline.
REQ-015 DONE SHALL assert dl_done for exactly one cycle, then return to IDLE.
REQ-016 CLEAR SHALL write 0 to addresses 0..DEPTH-1 in ascending order using only cycles without vid_req.
REQ-017 CLEAR->IDLE SHALL occur after address DEPTH-1 is written; the counter SHALL NOT wrap back to 0.
REQ-018 A rising edge of ioctl_download during CLEAR SHALL abort the clear and enter DOWNLOAD.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 ioctl_wr outside DOWNLOAD/FLUSH SHALL still be queued and written, with no state change.

Reset
REQ-021 While reset=1 and on the cycle after reset, outputs SHALL be: ram_we=0, ram_addr=0, ram_din=0, vid_valid=0, vid_data=0, ioctl_wait=0, busy=0, dl_done=0, err=0.
REQ-022 Reset SHALL empty the FIFO, flush the video pipeline without a vid_valid, clear the clear counter and enter IDLE.
REQ-023 Reset asserted mid-DOWNLOAD or mid-CLEAR SHALL abort the operation with no further RAM write; dl_done SHALL NOT pulse.

Verification
REQ-024 Video latency: vid_req=1 with vid_addr=0x0010 for 4 consecutive cycles, RAM preloaded with mem[0x10]=0xA5 -> vid_valid=1 for 4 cycles starting 3 cycles later, first vid_data=0xA5.
REQ-025 Contention: download addr 0x0100 data 0x3C issued while vid_req is held high for 10 cycles -> no ram_we for those 10 cycles, ioctl_wait=1; write lands the first cycle after vid_req drops; mem[0x100]=0x3C.
REQ-026 Full download: window of 256 writes to addresses 0..255 with random vid_req gaps -> all bytes correct; dl_done pulses once after the FIFO drains following the ioctl_download fall; err=0.
REQ-027 Errors: write to addr 0x10000 with ADDR_W=16 -> err[0]=1, no ram_we; three writes in 3 cycles with video saturating -> third write dropped, err[1]=1.
REQ-028 Clear: clr_req with ADDR_W=4 and vid_req on alternate cycles -> 16 zero writes at addresses 0..15 in order; busy falls after address 15; no address written twice.
REQ-029 Reset mid-clear: reset at clear address 7 -> ram_we=0 the next cycle, busy=0, mem[8..15] unchanged.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Signal bundle between vram_arbiter, its requesters (hps_io, video timing) and the VRAM.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [26:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic              clr_req;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vid_data;
    logic              vid_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic [7:0]        ram_dout;
    logic              busy;
    logic              dl_done;
    logic [1:0]        err;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, clr_req, vid_req, vid_addr, ram_dout,
        output ioctl_wait, vid_data, vid_valid, ram_addr, ram_din, ram_we, busy, dl_done, err
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, clr_req, vid_req, vid_addr, ram_dout,
        input  ioctl_wait, vid_data, vid_valid, ram_addr, ram_din, ram_we, busy, dl_done, err
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch > download write (2-entry FIFO) > clear fill,
// with a small FSM tracking download window and zero-fill progress.
module vram_arbiter #(
    parameter int ADDR_W = 16
) (
    input logic           clk_sys,
    input logic           reset,
    vram_arbiter_if.slave bus
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DOWNLOAD = 3'd1;
    localparam logic [2:0] ST_FLUSH    = 3'd2;
    localparam logic [2:0] ST_CLEAR    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam int         ENTRY_W     = ADDR_W + 8;

    logic [2:0]         state_q, state_d;
    logic               dl_prev_q;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;
    logic [1:0]         err_q, err_d;
    logic               ioctl_wait_q, ioctl_wait_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [7:0]         ram_din_q, ram_din_d;
    logic               ram_we_q, ram_we_d;
    logic               vid_s1_q, vid_s2_q, vid_valid_q;
    logic [7:0]         vid_data_q, vid_data_d;

    logic               dl_rise, dl_fall, addr_oor, wr_valid;
    logic               grant_wr, grant_clr, push, drop, err_clr;
    logic [ENTRY_W-1:0] wr_entry, head;

    // Two FIFO entries, each its own register so write-pointer decode stays local.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENTRY_W-1:0] entry_q, entry_d;
            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == 1'(gi))) begin
                    entry_d = wr_entry;
                end
            end
            always_ff @(posedge clk_sys) begin
                entry_q <= entry_d;
            end
        end
    endgenerate

    assign wr_entry = {bus.ioctl_addr[ADDR_W-1:0], bus.ioctl_dout};
    assign head     = rd_ptr_q ? g_fifo[1].entry_q : g_fifo[0].entry_q;

    always_comb begin
        dl_rise   = bus.ioctl_download & ~dl_prev_q;
        dl_fall   = ~bus.ioctl_download & dl_prev_q;
        addr_oor  = (bus.ioctl_addr >> ADDR_W) != '0;
        wr_valid  = bus.ioctl_wr & ~addr_oor;
        // Video always wins; queued writes come next; clear only fills fully idle slots.
        grant_wr  = ~bus.vid_req & (count_q != 2'd0);
        grant_clr = ~bus.vid_req & (count_q == 2'd0) & (state_q == ST_CLEAR) & ~dl_rise;
        push      = wr_valid & ((count_q != 2'd2) | grant_wr);
        drop      = wr_valid & ~push;
        count_d   = count_q + {1'b0, push} - {1'b0, grant_wr};
        rd_ptr_d  = rd_ptr_q ^ grant_wr;
        wr_ptr_d  = wr_ptr_q ^ push;
        ioctl_wait_d = (count_d != 2'd0);

        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        err_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dl_rise) begin
                    state_d = ST_DOWNLOAD;
                    err_clr = 1'b1;
                end else if (bus.clr_req && !bus.ioctl_download) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_DOWNLOAD: begin
                if (dl_fall) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Done only once nothing is queued, arriving, or being written.
                if ((count_q == 2'd0) && !push && !ram_we_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_CLEAR: begin
                if (dl_rise) begin
                    state_d = ST_DOWNLOAD;
                    err_clr = 1'b1;
                end else if (grant_clr) begin
                    if (clr_cnt_q == '1) begin
                        state_d = ST_IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_d = (err_clr ? 2'b00 : err_q) | {drop, bus.ioctl_wr & addr_oor};

        ram_we_d   = grant_wr | grant_clr;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        if (bus.vid_req) begin
            ram_addr_d = bus.vid_addr;
        end else if (grant_wr) begin
            ram_addr_d = head[ENTRY_W-1:8];
            ram_din_d  = head[7:0];
        end else if (grant_clr) begin
            ram_addr_d = clr_cnt_q;
            ram_din_d  = 8'h00;
        end

        vid_data_d = vid_s2_q ? bus.ram_dout : vid_data_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dl_prev_q    <= 1'b0;
            clr_cnt_q    <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            err_q        <= 2'b00;
            ioctl_wait_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= 8'h00;
            ram_we_q     <= 1'b0;
            vid_s1_q     <= 1'b0;
            vid_s2_q     <= 1'b0;
            vid_valid_q  <= 1'b0;
            vid_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            dl_prev_q    <= bus.ioctl_download;
            clr_cnt_q    <= clr_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            ioctl_wait_q <= ioctl_wait_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_we_q     <= ram_we_d;
            vid_s1_q     <= bus.vid_req;
            vid_s2_q     <= vid_s1_q;
            vid_valid_q  <= vid_s2_q;
            vid_data_q   <= vid_data_d;
        end
    end

    assign bus.ioctl_wait = ioctl_wait_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.vid_valid  = vid_valid_q;
    assign bus.vid_data   = vid_data_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.dl_done    = (state_q == ST_DONE);
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed steps plus randomized download/video traffic
// checked against a reference memory and a 3-cycle video latency queue.
module tb_vram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16, rst4;
    vram_arbiter_if #(.ADDR_W(16)) b16 ();
    vram_arbiter_if #(.ADDR_W(4))  b4 ();

    vram_arbiter #(.ADDR_W(16)) dut16 (.clk_sys(clk), .reset(rst16), .bus(b16.slave));
    vram_arbiter #(.ADDR_W(4))  dut4  (.clk_sys(clk), .reset(rst4),  .bus(b4.slave));

    // Behavioural single-port synchronous VRAMs with a bench-side preload port.
    logic [7:0]  vram16 [65536];
    logic [7:0]  vram4  [16];
    logic        pre16_we = 1'b0, pre4_we = 1'b0;
    logic [15:0] pre16_addr = '0;
    logic [3:0]  pre4_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (pre16_we) vram16[pre16_addr] <= pre_data;
        else if (b16.ram_we) vram16[b16.ram_addr] <= b16.ram_din;
        b16.ram_dout <= vram16[b16.ram_addr];
    end

    always @(posedge clk) begin
        if (pre4_we) vram4[pre4_addr] <= pre_data;
        else if (b4.ram_we) vram4[b4.ram_addr] <= b4.ram_din;
        b4.ram_dout <= vram4[b4.ram_addr];
    end

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] vid_ref [16];
    logic [7:0] ref_mem [256];
    int         vq_due[$];
    logic [7:0] vq_dat[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pre16(input logic [15:0] a, input logic [7:0] v);
        pre16_we = 1'b1; pre16_addr = a; pre_data = v;
        tick();
        pre16_we = 1'b0;
    endtask

    task automatic fill4(input logic [7:0] v);
        for (int i = 0; i < 16; i++) begin
            pre4_we = 1'b1; pre4_addr = 4'(i); pre_data = v;
            tick();
        end
        pre4_we = 1'b0;
    endtask

    // Video model: a request at cycle c returns vid_ref data exactly at cycle c+3.
    task automatic vid_step16(input bit allow);
        logic exp_v;
        int   idx;
        exp_v = (vq_due.size() > 0) && (vq_due[0] == cyc);
        check("rnd_vid_valid", b16.vid_valid, exp_v);
        if (exp_v) begin
            check("rnd_vid_data", b16.vid_data, vq_dat[0]);
            void'(vq_due.pop_front());
            void'(vq_dat.pop_front());
        end
        b16.vid_req = allow ? 1'($urandom_range(0, 1)) : 1'b0;
        if (b16.vid_req) begin
            idx = $urandom_range(0, 15);
            b16.vid_addr = 16'h8000 + 16'(idx);
            vq_due.push_back(cyc + 3);
            vq_dat.push_back(vid_ref[idx]);
        end
    endtask

    task automatic count_done16(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (b16.dl_done) pulses++;
            tick();
        end
    endtask

    initial begin
        int         next_a, guard, pulses, bad;
        logic [7:0] d;
        logic       last_vid, found;
        int         wq[$];

        rst16 = 1'b1; rst4 = 1'b1;
        b16.ioctl_download = 0; b16.ioctl_wr = 0; b16.ioctl_addr = '0; b16.ioctl_dout = '0;
        b16.clr_req = 0; b16.vid_req = 0; b16.vid_addr = '0;
        b4.ioctl_download = 0; b4.ioctl_wr = 0; b4.ioctl_addr = '0; b4.ioctl_dout = '0;
        b4.clr_req = 0; b4.vid_req = 0; b4.vid_addr = '0;
        repeat (2) tick();

        check("rst16_hold", {b16.ram_we, b16.ram_addr, b16.ram_din, b16.vid_valid, b16.vid_data,
                             b16.ioctl_wait, b16.busy, b16.dl_done, b16.err}, 64'd0);
        check("rst4_hold", {b4.ram_we, b4.ram_addr, b4.ram_din, b4.vid_valid, b4.vid_data,
                            b4.ioctl_wait, b4.busy, b4.dl_done, b4.err}, 64'd0);

        pre16(16'h0010, 8'hA5);
        pre16(16'h0202, 8'h00);
        for (int i = 0; i < 16; i++) begin
            vid_ref[i] = 8'($urandom);
            pre16(16'h8000 + 16'(i), vid_ref[i]);
        end
        fill4(8'hFF);

        rst16 = 1'b0; rst4 = 1'b0;
        tick();
        check("rst16_after", {b16.ram_we, b16.ram_addr, b16.ram_din, b16.vid_valid, b16.vid_data,
                              b16.ioctl_wait, b16.busy, b16.dl_done, b16.err}, 64'd0);
        check("rst4_after", {b4.ram_we, b4.ram_addr, b4.ram_din, b4.vid_valid, b4.vid_data,
                             b4.ioctl_wait, b4.busy, b4.dl_done, b4.err}, 64'd0);

        // Video latency: 4 back-to-back fetches of 0x0010.
        for (int i = 0; i < 9; i++) begin
            b16.vid_req = (i < 4); b16.vid_addr = 16'h0010;
            if (i == 1) check("vid_issue", {b16.ram_we, b16.ram_addr}, {1'b0, 16'h0010});
            check("vid_lat_valid", b16.vid_valid, (i >= 3 && i < 7));
            if (i >= 3 && i < 7) check("vid_lat_data", b16.vid_data, 8'hA5);
            tick();
        end
        b16.vid_req = 1'b0;

        // Contention: one write held off by 10 cycles of video.
        b16.ioctl_download = 1; b16.ioctl_wr = 1; b16.ioctl_addr = 27'h100; b16.ioctl_dout = 8'h3C;
        b16.vid_req = 1; b16.vid_addr = 16'h8000;
        tick();
        b16.ioctl_wr = 0;
        check("dl_busy", b16.busy, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            b16.vid_req = (i < 10);
            check("cont_no_we", b16.ram_we, 1'b0);
            check("cont_wait", b16.ioctl_wait, 1'b1);
            tick();
        end
        check("cont_we", {b16.ram_we, b16.ram_addr, b16.ram_din}, {1'b1, 16'h0100, 8'h3C});
        check("cont_wait_clr", b16.ioctl_wait, 1'b0);
        tick();
        check("cont_mem", vram16[16'h0100], 8'h3C);
        b16.ioctl_download = 0;
        count_done16(10, pulses);
        check("cont_done_pulses", pulses, 1);
        check("cont_idle", b16.busy, 1'b0);

        // Full 256-byte download with random video traffic.
        b16.ioctl_download = 1;
        next_a = 0; guard = 0;
        while (next_a < 256 && guard < 5000) begin
            vid_step16(1'b1);
            if (!b16.ioctl_wait && $urandom_range(0, 3) != 0) begin
                d = 8'($urandom);
                b16.ioctl_wr = 1; b16.ioctl_addr = 27'(next_a); b16.ioctl_dout = d;
                ref_mem[next_a] = d;
                next_a++;
            end else begin
                b16.ioctl_wr = 0;
            end
            tick();
            guard++;
        end
        b16.ioctl_wr = 0;
        check("dl_issued", next_a, 256);
        b16.ioctl_download = 0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            vid_step16(1'b1);
            if (b16.dl_done) begin
                pulses++;
                check("dl_done_drained", b16.ioctl_wait, 1'b0);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            vid_step16(1'b0);
            tick();
        end
        check("dl_pulses", pulses, 1);
        check("dl_err", b16.err, 2'b00);
        check("dl_idle", b16.busy, 1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (vram16[i] !== ref_mem[i]) bad++;
        check("dl_bytes_bad", bad, 0);

        // Out-of-range write: dropped, err[0] set, aliased address 0 untouched.
        b16.ioctl_wr = 1; b16.ioctl_addr = 27'h10000; b16.ioctl_dout = ~ref_mem[0];
        tick();
        b16.ioctl_wr = 0;
        check("oor_err", b16.err, 2'b01);
        check("oor_wait", b16.ioctl_wait, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("oor_no_we", b16.ram_we, 1'b0);
            tick();
        end
        check("oor_mem0", vram16[0], ref_mem[0]);

        // Overflow: three writes in a row under saturating video.
        b16.vid_req = 1; b16.vid_addr = 16'h8000;
        for (int k = 0; k < 3; k++) begin
            b16.ioctl_wr = 1; b16.ioctl_addr = 27'h200 + 27'(k); b16.ioctl_dout = 8'h40 + 8'(k);
            tick();
        end
        b16.ioctl_wr = 0;
        check("ovf_err", b16.err, 2'b11);
        b16.vid_req = 0;
        repeat (6) tick();
        check("ovf_mem0", vram16[16'h0200], 8'h40);
        check("ovf_mem1", vram16[16'h0201], 8'h41);
        check("ovf_mem2_dropped", vram16[16'h0202], 8'h00);
        b16.ioctl_download = 1;
        tick();
        check("err_cleared", b16.err, 2'b00);
        b16.ioctl_download = 0;
        count_done16(10, pulses);
        check("err_dl_pulses", pulses, 1);

        // Download rising edge beats a simultaneous clear request.
        b4.ioctl_download = 1; b4.clr_req = 1;
        tick();
        b4.clr_req = 0;
        for (int i = 0; i < 4; i++) begin
            check("prio_no_we", b4.ram_we, 1'b0);
            check("prio_busy", b4.busy, 1'b1);
            tick();
        end
        b4.ioctl_download = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (b4.dl_done) pulses++;
            tick();
        end
        check("prio_done_pulses", pulses, 1);

        // Clear with video on alternate cycles; a second clr_req mid-clear is ignored.
        b4.clr_req = 1;
        tick();
        b4.clr_req = 0;
        check("clr_busy", b4.busy, 1'b1);
        last_vid = 1'b0; found = 1'b0;
        for (int g = 0; g < 100; g++) begin
            if (b4.ram_we) begin
                wq.push_back(int'(b4.ram_addr));
                check("clr_din", b4.ram_din, 8'h00);
                check("clr_slot", last_vid, 1'b0);
            end
            if (!b4.busy) begin
                found = 1'b1;
                break;
            end
            b4.clr_req = (g == 3);
            b4.vid_req = g[0];
            b4.vid_addr = 4'(g);
            last_vid = b4.vid_req;
            tick();
        end
        b4.clr_req = 0; b4.vid_req = 0;
        check("clr_finished", found, 1'b1);
        check("clr_count", wq.size(), 16);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) if (wq[i] != i) bad++;
        check("clr_order_bad", bad, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("clr_no_wrap", b4.ram_we, 1'b0);
            tick();
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (vram4[i] !== 8'h00) bad++;
        check("clr_zero_bad", bad, 0);

        // Reset while clearing address 7.
        fill4(8'h5A);
        b4.clr_req = 1;
        tick();
        b4.clr_req = 0;
        found = 1'b0;
        for (int g = 0; g < 100; g++) begin
            if (b4.ram_we && b4.ram_addr == 4'd7) begin
                found = 1'b1;
                rst4 = 1'b1;
                break;
            end
            tick();
        end
        check("rstclr_reached7", found, 1'b1);
        tick();
        check("rstclr_we", b4.ram_we, 1'b0);
        check("rstclr_busy", b4.busy, 1'b0);
        tick();
        rst4 = 1'b0;
        pulses = 0; bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (b4.ram_we) bad++;
            if (b4.dl_done) pulses++;
            tick();
        end
        check("rstclr_no_we_after", bad, 0);
        check("rstclr_no_done", pulses, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) if (vram4[i] !== 8'h00) bad++;
        for (int i = 8; i < 16; i++) if (vram4[i] !== 8'h5A) bad++;
        check("rstclr_mem_bad", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
